// File: rtl/mlp_load_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mlp_load_sequencer                                             |
// | Purpose : Load-stream master for the MLP accelerator. Reads input rows   |
// |           and 8 weight layers from a 1-cycle-latency word SRAM, streams  |
// |           them in interleaved order, then captures the result stream     |
// |           into a result SRAM and pulses done (or error on timeout).      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
// Timing reference: with start_i sampled at edge 0, the read for beat j is
// presented to the SRAM ahead of edge j+1 and the matching load beat is
// registered at edge j+2.
module mlp_load_sequencer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int RES_BEATS = 128,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              load_en_o,
  output logic [DATA_W-1:0] load_payload_o,
  output logic              load_type_o,
  output logic [3:0]        input_load_number_o,
  output logic [2:0]        layer_number_o,
  output logic [2:0]        weight_number_o,
  input  logic              result_valid_i,
  input  logic [DATA_W-1:0] result_payload_i,
  output logic              res_wr_en_o,
  output logic [6:0]        res_wr_addr_o,
  output logic [DATA_W-1:0] res_wr_data_o
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STREAM   = 3'd1,
    S_WAIT_RES = 3'd2,
    S_COLLECT  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t r_state, w_next;

  // Stream position: layer / row / word, plus whether the current row of
  // layer 0 is still in its input-beat half.
  logic [2:0]  r_layer;
  logic [3:0]  r_row;
  logic [2:0]  r_word;
  logic        r_is_input;

  // Sideband for the read in flight, aligned to data arriving next cycle.
  logic        r_pend;
  logic        r_pend_type;
  logic [3:0]  r_pend_row;
  logic [2:0]  r_pend_layer;
  logic [2:0]  r_pend_w;

  logic        r_load_en;
  logic [DATA_W-1:0] r_load_payload;
  logic        r_load_type;
  logic [3:0]  r_load_row;
  logic [2:0]  r_load_layer;
  logic [2:0]  r_load_w;

  logic [6:0]  r_res_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic        r_res_wr_en;
  logic [6:0]  r_res_wr_addr;
  logic [DATA_W-1:0] r_res_wr_data;
  logic        r_done;
  logic        r_error;

  logic        w_rd_en;
  logic        w_last_beat;
  logic        w_last_res;
  logic        w_timeout;
  logic        w_capture;
  logic [3:0]  w_layer_p1;
  logic [10:0] w_addr_full;

  assign w_rd_en     = (r_state == S_STREAM);
  assign w_last_beat = (r_word == 3'd7) && !r_is_input && (r_row == 4'd15) && (r_layer == 3'd7);
  assign w_last_res  = (r_res_cnt == 7'(RES_BEATS - 1));
  assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_capture   = result_valid_i && ((r_state == S_WAIT_RES) || (r_state == S_COLLECT));

  // Weight region starts at word 128, so layer l lives at (l+1)*128.
  assign w_layer_p1  = {1'b0, r_layer} + 4'd1;
  assign w_addr_full = r_is_input ? {4'd0, r_row, r_word} : {w_layer_p1, r_row, r_word};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start_i) w_next = S_STREAM;
      S_STREAM:   if (w_last_beat) w_next = S_WAIT_RES;
      S_WAIT_RES: begin
        if (result_valid_i) w_next = w_last_res ? S_DONE : S_COLLECT;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_COLLECT:  if (result_valid_i && w_last_res) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Stream position counters; cleared while idle so a start begins at beat 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_layer    <= 3'd0;
      r_row      <= 4'd0;
      r_word     <= 3'd0;
      r_is_input <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_layer    <= 3'd0;
      r_row      <= 4'd0;
      r_word     <= 3'd0;
      r_is_input <= 1'b1;
    end else if (r_state == S_STREAM) begin
      if (r_word != 3'd7) begin
        r_word <= r_word + 3'd1;
      end else begin
        r_word <= 3'd0;
        if (r_is_input) begin
          r_is_input <= 1'b0;
        end else begin
          r_row      <= r_row + 4'd1;
          if (r_row == 4'd15) r_layer <= r_layer + 3'd1;
          // Only layer 0 rows carry input beats ahead of their weights.
          r_is_input <= (r_layer == 3'd0) && (r_row != 4'd15);
        end
      end
    end
  end

  // Sideband stage for the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= 1'b0;
      r_pend_type  <= 1'b0;
      r_pend_row   <= 4'd0;
      r_pend_layer <= 3'd0;
      r_pend_w     <= 3'd0;
    end else begin
      r_pend       <= w_rd_en;
      r_pend_type  <= w_rd_en && r_is_input;
      r_pend_row   <= w_rd_en ? r_row : 4'd0;
      r_pend_layer <= (w_rd_en && !r_is_input) ? r_layer : 3'd0;
      r_pend_w     <= (w_rd_en && !r_is_input) ? r_word : 3'd0;
    end
  end

  // Load beat register: SRAM data joined with its delayed sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_en      <= 1'b0;
      r_load_payload <= '0;
      r_load_type    <= 1'b0;
      r_load_row     <= 4'd0;
      r_load_layer   <= 3'd0;
      r_load_w       <= 3'd0;
    end else begin
      r_load_en      <= r_pend;
      r_load_payload <= r_pend ? mem_rd_data_i : '0;
      r_load_type    <= r_pend_type;
      r_load_row     <= r_pend_row;
      r_load_layer   <= r_pend_layer;
      r_load_w       <= r_pend_w;
    end
  end

  // Result capture, beat counter, timeout counter and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_cnt     <= 7'd0;
      r_to_cnt      <= '0;
      r_res_wr_en   <= 1'b0;
      r_res_wr_addr <= 7'd0;
      r_res_wr_data <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_res_wr_en   <= w_capture;
      r_res_wr_addr <= w_capture ? r_res_cnt : 7'd0;
      r_res_wr_data <= w_capture ? result_payload_i : '0;
      if (r_state == S_IDLE)  r_res_cnt <= 7'd0;
      else if (w_capture)     r_res_cnt <= r_res_cnt + 7'd1;
      r_to_cnt      <= (r_state == S_WAIT_RES) ? r_to_cnt + TO_W'(1) : '0;
      r_done        <= (r_state == S_DONE);
      r_error       <= (r_state == S_WAIT_RES) && !result_valid_i && w_timeout;
    end
  end

  assign busy_o              = (r_state != S_IDLE);
  assign done_o              = r_done;
  assign error_o             = r_error;
  assign mem_rd_en_o         = w_rd_en;
  assign mem_rd_addr_o       = w_rd_en ? ADDR_W'(w_addr_full) : '0;
  assign load_en_o           = r_load_en;
  assign load_payload_o      = r_load_payload;
  assign load_type_o         = r_load_type;
  assign input_load_number_o = r_load_row;
  assign layer_number_o      = r_load_layer;
  assign weight_number_o     = r_load_w;
  assign res_wr_en_o         = r_res_wr_en;
  assign res_wr_addr_o       = r_res_wr_addr;
  assign res_wr_data_o       = r_res_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mlp_load_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mlp_load_sequencer                                          |
// | Purpose : Directed self-checking bench for mlp_load_sequencer.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
// Cycle numbering in this bench: k = value observed 1 ns after edge k,
// where edge 0 is the edge that samples start_i.
module tb_mlp_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, error_o;
  logic        mem_rd_en_o;
  logic [10:0] mem_rd_addr_o;
  logic [31:0] mem_rd_data = 32'd0;
  logic        load_en_o;
  logic [31:0] load_payload_o;
  logic        load_type_o;
  logic [3:0]  input_load_number_o;
  logic [2:0]  layer_number_o;
  logic [2:0]  weight_number_o;
  logic        result_valid = 1'b0;
  logic [31:0] result_payload = 32'd0;
  logic        res_wr_en_o;
  logic [6:0]  res_wr_addr_o;
  logic [31:0] res_wr_data_o;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [31:0] res_mem [0:127];

  mlp_load_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_i             (start_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .error_o             (error_o),
    .mem_rd_en_o         (mem_rd_en_o),
    .mem_rd_addr_o       (mem_rd_addr_o),
    .mem_rd_data_i       (mem_rd_data),
    .load_en_o           (load_en_o),
    .load_payload_o      (load_payload_o),
    .load_type_o         (load_type_o),
    .input_load_number_o (input_load_number_o),
    .layer_number_o      (layer_number_o),
    .weight_number_o     (weight_number_o),
    .result_valid_i      (result_valid),
    .result_payload_i    (result_payload),
    .res_wr_en_o         (res_wr_en_o),
    .res_wr_addr_o       (res_wr_addr_o),
    .res_wr_data_o       (res_wr_data_o)
  );

  always #5 clk = ~clk;

  // Source SRAM contents: word a carries a in both halves.
  function automatic logic [31:0] sram_word(input int a);
    logic [10:0] a11;
    a11 = a[10:0];
    return {5'd0, a11, 5'd0, a11};
  endfunction

  // One-cycle-latency source SRAM.
  always @(posedge clk) if (mem_rd_en_o) mem_rd_data <= sram_word(int'(mem_rd_addr_o));

  // Result SRAM.
  always @(posedge clk) if (res_wr_en_o) res_mem[res_wr_addr_o] <= res_wr_data_o;

  always @(negedge clk) begin
    if (done_o)  done_cnt++;
    if (error_o) err_cnt++;
  end

  // Reference beat order, derived directly from the address map.
  function automatic void beat_model(input int j, output int addr, output logic typ,
                                     output int row, output int layer, output int w);
    int jj;
    if (j < 256) begin
      row = j / 16;
      layer = 0;
      if ((j % 16) < 8) begin
        typ = 1'b1; w = 0; addr = row * 8 + (j % 16);
      end else begin
        typ = 1'b0; w = (j % 16) - 8; addr = 128 + row * 8 + w;
      end
    end else begin
      jj = j - 256;
      typ = 1'b0;
      layer = 1 + jj / 128;
      row = (jj % 128) / 8;
      w = jj % 8;
      addr = 128 + layer * 128 + row * 8 + w;
    end
  endfunction

  // Starts a run and checks every read/load cycle through k = 1154.
  task automatic run_stream(input bit hold_start, input string tag);
    int addr_j, row_j, layer_j, w_j;
    logic typ_j;
    logic rd_e;
    logic [10:0] rd_a;
    logic [43:0] ld;
    logic [58:0] exp_v, act_v;
    start_i = 1'b1;
    for (int k = 0; k <= 1154; k++) begin
      @(posedge clk); #1;
      if (!hold_start || k >= 1150) start_i = 1'b0;
      rd_e = (k <= 1151);
      rd_a = 11'd0;
      if (rd_e) begin
        beat_model(k, addr_j, typ_j, row_j, layer_j, w_j);
        rd_a = 11'(addr_j);
      end
      ld = '0;
      if (k >= 2 && k <= 1153) begin
        beat_model(k - 2, addr_j, typ_j, row_j, layer_j, w_j);
        ld = {1'b1, typ_j, 4'(row_j), 3'(layer_j), 3'(w_j), sram_word(addr_j)};
      end
      exp_v = {1'b1, 1'b0, 1'b0, rd_e, rd_a, ld};
      act_v = {busy_o, done_o, error_o, mem_rd_en_o, mem_rd_addr_o, load_en_o, load_type_o,
               input_load_number_o, layer_number_o, weight_number_o, load_payload_o};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {busy,done,err,rd,addr,ld,type,row,layer,w,data} got %h want %h",
                 tag, k, act_v, exp_v);
      end
    end
    start_i = 1'b0;
  endtask

  // Drives 128 result beats (optionally with gaps) and checks capture and done.
  task automatic run_results(input bit gaps, input logic [31:0] salt, input string tag);
    int done_before;
    logic [39:0] exp_w, act_w;
    done_before = done_cnt;
    for (int j = 0; j < 128; j++) begin
      if (gaps && (j % 7 == 3)) begin
        result_valid = 1'b0;
        result_payload = 32'hDEAD_0000;
        @(posedge clk); #1;
        n_checks++;
        if (res_wr_en_o !== 1'b0 || busy_o !== 1'b1) begin
          n_fail++;
          $display("FAIL %s gap before beat %0d: wr_en=%b busy=%b want wr_en=0 busy=1",
                   tag, j, res_wr_en_o, busy_o);
        end
      end
      result_valid = 1'b1;
      result_payload = salt + 32'(j);
      @(posedge clk); #1;
      exp_w = {1'b1, 7'(j), salt + 32'(j)};
      act_w = {res_wr_en_o, res_wr_addr_o, res_wr_data_o};
      n_checks++;
      if (act_w !== exp_w || done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s write beat %0d: {en,addr,data}=%h done=%b want %h done=0",
                 tag, j, act_w, done_o, exp_w);
      end
    end
    // Extra valid beats after the last one must be ignored.
    result_payload = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || res_wr_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done pulse: done=%b busy=%b wr_en=%b want 1 0 0", tag, done_o, busy_o, res_wr_en_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done_o !== 1'b0 || res_wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after done: done=%b wr_en=%b busy=%b want 0 0 0", tag, done_o, res_wr_en_o, busy_o);
    end
    result_valid = 1'b0;
    n_checks++;
    if (done_cnt - done_before !== 1) begin
      n_fail++;
      $display("FAIL %s done count: got %0d want 1", tag, done_cnt - done_before);
    end
    for (int j = 0; j < 128; j++) begin
      n_checks++;
      if (res_mem[j] !== salt + 32'(j)) begin
        n_fail++;
        $display("FAIL %s res_mem[%0d]: got %h want %h", tag, j, res_mem[j], salt + 32'(j));
      end
    end
  endtask

  task automatic test_reset();
    logic [27:0] act_v;
    repeat (3) @(posedge clk);
    #1;
    act_v = {busy_o, done_o, error_o, mem_rd_en_o, mem_rd_addr_o, load_en_o, load_type_o,
             input_load_number_o, layer_number_o, weight_number_o, res_wr_en_o};
    n_checks++;
    if (act_v !== '0 || load_payload_o !== '0 || res_wr_addr_o !== '0 || res_wr_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ctrl=%h payload=%h res_addr=%h res_data=%h want all 0",
               act_v, load_payload_o, res_wr_addr_o, res_wr_data_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy_o !== 1'b0 || mem_rd_en_o !== 1'b0 || load_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b rd=%b ld=%b want 0", busy_o, mem_rd_en_o, load_en_o);
    end
    // Abort mid-stream with an asynchronous reset.
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    n_checks++;
    if (load_en_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midstream_active: load_en=%b busy=%b want 1 1", load_en_o, busy_o);
    end
    rst_n = 1'b0;
    #1;
    act_v = {busy_o, done_o, error_o, mem_rd_en_o, mem_rd_addr_o, load_en_o, load_type_o,
             input_load_number_o, layer_number_o, weight_number_o, res_wr_en_o};
    n_checks++;
    if (act_v !== '0 || load_payload_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset_abort: ctrl=%h payload=%h want 0", act_v, load_payload_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy_o !== 1'b0 || done_cnt !== 0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL abort_no_pulse: busy=%b done_cnt=%0d err_cnt=%0d want 0 0 0", busy_o, done_cnt, err_cnt);
    end
  endtask

  task automatic test_order_and_results();
    run_stream(1'b0, "order");
    run_results(1'b0, 32'h0000_0000, "results");
  endtask

  task automatic test_gaps();
    int err_before;
    err_before = err_cnt;
    run_stream(1'b0, "gaps_stream");
    // Idle a few cycles in WAIT_RES before the first beat.
    repeat (5) @(posedge clk);
    #1;
    run_results(1'b1, 32'h5A00_0100, "gaps");
    n_checks++;
    if (err_cnt !== err_before) begin
      n_fail++;
      $display("FAIL gaps_no_error: error pulses got %0d want 0", err_cnt - err_before);
    end
  endtask

  task automatic test_start_while_busy();
    run_stream(1'b1, "busy_start");
    run_results(1'b0, 32'h0BAD_0000, "busy_start_res");
  endtask

  task automatic test_timeout();
    int err_k;
    int done_before;
    err_k = -1;
    done_before = done_cnt;
    run_stream(1'b0, "timeout_stream");
    for (int k = 1155; k <= 6000; k++) begin
      @(posedge clk); #1;
      if (error_o === 1'b1) begin
        err_k = k;
        break;
      end
    end
    n_checks++;
    if (err_k != 5248) begin
      n_fail++;
      $display("FAIL timeout_cycle: error_o first seen at cycle %0d want 5248", err_k);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_busy: busy=%b want 0", busy_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (error_o !== 1'b0 || done_cnt !== done_before) begin
      n_fail++;
      $display("FAIL timeout_pulse: error=%b done pulses=%0d want 0 0", error_o, done_cnt - done_before);
    end
  endtask

  initial begin
    test_reset();
    test_order_and_results();
    test_gaps();
    test_start_while_busy();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
